// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    localparam int          ADDRESS_WIDTH_DEF = 12;
    localparam int          DATA_WIDTH_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF      = 32'd0;
    localparam int          PC_WIDTH          = 32;

    // Word-addressed program counter.
    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry instruction output buffer with flush; head entry drives the consumer directly.
// Latency: a push is visible at the head on the cycle after the push edge when the buffer was empty.
// Backpressure: the producer must not push into a full buffer unless it also pops that cycle.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  pc_t                   push_pc,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output pc_t                   head_pc,
    output logic [DATA_WIDTH-1:0] head_data
);

    pc_t                   tail_pc;
    logic [DATA_WIDTH-1:0] tail_data;

    // Head/tail shift register; head keeps its last value once drained so the
    // consumer-facing outputs only change on a real update or on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 2'd0;
            head_pc   <= '0;
            head_data <= '0;
            tail_pc   <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                        count     <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                        count     <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_pc   <= tail_pc;
                        head_data <= tail_data;
                    end
                    if (count != 2'd0) begin
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    // Net occupancy unchanged; a pop only happens with count >= 1.
                    if (count == 2'd2) begin
                        head_pc   <= tail_pc;
                        head_data <= tail_data;
                        tail_pc   <= push_pc;
                        tail_data <= push_data;
                    end else begin
                        head_pc   <= push_pc;
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, synchronous-ROM issue, and a 2-entry output buffer.
// Latency: issue at cycle N, ROM data at N+1, instr_valid at N+2; redirect at R gives instr_valid at R+3.
// Backpressure: issue stops once buffered plus in-flight words reach 2 unless a pop frees a slot that cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int          DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter logic [31:0] RESET_PC      = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [31:0]              instr_pc
);

    pc_t        fetch_pc;
    pc_t        inflight_pc;
    logic       inflight;
    logic [1:0] count;
    logic [2:0] occupancy;
    logic       pop;
    logic       issue;
    logic       capture;

    assign rom_addr    = fetch_pc[ADDRESS_WIDTH-1:0];
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign occupancy   = {1'b0, count} + {2'b00, inflight};

    // Issue while a slot is guaranteed for the returning word; redirect suppresses both issue and capture.
    always_comb begin
        issue   = 1'b0;
        capture = inflight & ~redirect_valid;
        if (!redirect_valid) begin
            issue = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
        end
    end

    // PC and in-flight tracking; redirect has highest priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd1;
            end
        end
    end

    fetch_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (capture),
        .push_pc   (inflight_pc),
        .push_data (rom_data),
        .pop       (pop),
        .count     (count),
        .head_pc   (instr_pc),
        .head_data (instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a synchronous ROM model (ROM[a] = a + 0x100).
// Expected PC streams are queued whenever reset or a redirect is driven and popped on each handshake.
module tb_fetch_unit;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr;
    logic [31:0]   instr_pc;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_q[$];

    fetch_unit #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .RESET_PC      (32'd0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM: data for the address presented appears after the edge.
    always @(posedge clk) rom_data <= {20'd0, rom_addr} + 32'h100;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [11:0] a;
        a = pc[11:0];
        return {20'd0, a} + 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_q(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i));
    endtask

    // Score the handshake that the next edge will perform, then advance one cycle.
    task automatic step();
        logic [31:0] e;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", 64'(instr_pc), 64'(e));
                chk("pop_instr", 64'(instr), 64'(rom_word(e)));
            end
        end
        if (redirect_valid) load_q(redirect_pc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        // Asynchronous reset assertion before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", 64'(instr_pc), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset release, streaming with ready held high.
        reset_n = 1'b1;
        instr_ready = 1'b1;
        load_q(32'd0);
        step();
        chk("fill_valid_c1", 64'(instr_valid), 64'd0);
        step();
        chk("fill_valid_c2", 64'(instr_valid), 64'd1);
        chk("fill_first_pc", 64'(instr_pc), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stream_valid", 64'(instr_valid), 64'd1);
        end

        // Stall at pc 3 for 5 cycles.
        k = 0;
        while (!(instr_valid && instr_pc == 32'd3) && k < 20) begin
            step();
            k++;
        end
        chk("reach_pc3", 64'(instr_pc), 64'd3);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rom_addr", 64'(rom_addr), 64'd5);
            chk("stall_head_pc", 64'(instr_pc), 64'd3);
        end
        chk("stall_count", 64'(dut.u_buf.count), 64'd2);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("resume_valid", 64'(instr_valid), 64'd1);
        end

        // Redirect into a full buffer.
        instr_ready = 1'b0;
        repeat (3) step();
        chk("pre_redir_count", 64'(dut.u_buf.count), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        chk("redir_valid_c1", 64'(instr_valid), 64'd0);
        step();
        chk("redir_valid_c2", 64'(instr_valid), 64'd0);
        step();
        chk("redir_valid_c3", 64'(instr_valid), 64'd1);
        chk("redir_first_pc", 64'(instr_pc), 64'h40);
        chk("redir_first_instr", 64'(instr), 64'h140);
        repeat (3) step();

        // Redirect coincident with a pop and a ROM capture.
        chk("coinc_pre_valid", 64'(instr_valid), 64'd1);
        chk("coinc_pre_inflight", 64'(dut.inflight), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("coinc_flushed", 64'(instr_valid), 64'd0);
        step();
        chk("coinc_valid_c2", 64'(instr_valid), 64'd0);
        step();
        chk("coinc_first_pc", 64'(instr_pc), 64'h80);
        repeat (3) step();

        // ROM address wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'd4094;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'd4094 + 32'(i);
            chk("wrap_rom_addr", 64'(rom_addr), 64'(a[11:0]));
            step();
        end
        repeat (4) step();
        chk("wrap_consumed", 64'(exp_q[0]), 64'd4100);

        // Asynchronous reset with a full buffer.
        instr_ready = 1'b0;
        repeat (3) step();
        chk("prerst_valid", 64'(instr_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk("arst_instr", 64'(instr), 64'd0);
        chk("arst_pc", 64'(instr_pc), 64'd0);
        chk("arst_rom_addr", 64'(rom_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        instr_ready = 1'b1;
        load_q(32'd0);
        step();
        chk("restart_valid_c1", 64'(instr_valid), 64'd0);
        step();
        chk("restart_valid_c2", 64'(instr_valid), 64'd1);
        chk("restart_pc", 64'(instr_pc), 64'd0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
